// File: rtl/ff_bank_ctrl.sv
// Round-robin arbiter that gives four requesters turns at one shared D flip-flop
// register, sequencing each load/clear/preset through GRANT, APPLY and DONE.
module ff_bank_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [7:0]         op,
    input  logic [4*WIDTH-1:0] din,
    input  logic [WIDTH-1:0]   Q_in,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   ff_D,
    output logic               ff_en,
    output logic               ff_clear,
    output logic               ff_preset,
    output logic [WIDTH-1:0]   rdata,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, GRANT, APPLY, DONE} state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   ff_d_q, ff_d_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         ack_q, ack_d;
    logic               ff_en_q, ff_en_d;
    logic               ff_clear_q, ff_clear_d;
    logic               ff_preset_q, ff_preset_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [1:0]         pick;
    logic [1:0]         idx;
    logic [1:0]         pick_op;
    logic [WIDTH-1:0]   pick_din;

    // First requesting index at or above ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_op  = '0;
        pick_din = '0;
        for (int i = 0; i < 4; i++) begin
            if (pick == 2'(i)) begin
                pick_op  = op[2*i +: 2];
                pick_din = din[WIDTH*i +: WIDTH];
            end
        end
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        ff_d_d  = ff_d_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    win_d   = pick;
                    op_d    = pick_op;
                    ff_d_d  = pick_din;
                    ptr_d   = pick + 2'd1;
                end
            end
            GRANT:   state_d = APPLY;
            APPLY:   state_d = DONE;
            DONE: begin
                state_d = IDLE;
                rdata_d = Q_in;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        gnt_d       = busy_d ? (4'b0001 << win_d) : 4'b0000;
        ack_d       = (state_d == DONE) ? (4'b0001 << win_d) : 4'b0000;
        ff_en_d     = (state_d == APPLY) && (op_d == OP_LOAD);
        ff_clear_d  = (state_d == APPLY) && (op_d == OP_CLEAR);
        ff_preset_d = (state_d == APPLY) && (op_d == OP_PRESET);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            op_q        <= '0;
            ff_d_q      <= '0;
            rdata_q     <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            ff_en_q     <= 1'b0;
            ff_clear_q  <= 1'b0;
            ff_preset_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            op_q        <= op_d;
            ff_d_q      <= ff_d_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            ff_en_q     <= ff_en_d;
            ff_clear_q  <= ff_clear_d;
            ff_preset_q <= ff_preset_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign ff_D      = ff_d_q;
    assign ff_en     = ff_en_q;
    assign ff_clear  = ff_clear_q;
    assign ff_preset = ff_preset_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ff_bank_ctrl.sv
// Directed bench for ff_bank_ctrl; a behavioural model of the shared register
// feeds Q_in so rdata can be predicted from the strobes the controller issues.
module tb_ff_bank_ctrl;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset_n;
    logic [3:0]         req;
    logic [7:0]         op;
    logic [4*WIDTH-1:0] din;
    logic [WIDTH-1:0]   Q_in;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   ff_D;
    logic               ff_en;
    logic               ff_clear;
    logic               ff_preset;
    logic [WIDTH-1:0]   rdata;
    logic               busy;

    logic [WIDTH-1:0]   reg_model;
    int                 checks;
    int                 errors;
    int                 exp_win;

    ff_bank_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .op        (op),
        .din       (din),
        .Q_in      (Q_in),
        .gnt       (gnt),
        .ack       (ack),
        .ff_D      (ff_D),
        .ff_en     (ff_en),
        .ff_clear  (ff_clear),
        .ff_preset (ff_preset),
        .rdata     (rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The external register this controller drives.
    initial reg_model = '0;
    always @(posedge clk) begin
        if (ff_clear)
            reg_model <= '0;
        else if (ff_preset)
            reg_model <= '1;
        else if (ff_en)
            reg_model <= ff_D;
    end
    assign Q_in = reg_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] o, input logic [31:0] d);
        req = r;
        op  = o;
        din = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        tick();
        checkOutput("rst_gnt", gnt, 4'b0000);
        checkOutput("rst_ack", ack, 4'b0000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_strobes", {ff_en, ff_clear, ff_preset}, 3'b000);
        checkOutput("rst_ffd", ff_D, 8'h00);
        checkOutput("rst_rdata", rdata, 8'h00);
        reset_n = 1'b1;
        tick();

        $display("[TB] single load by requester 0");
        applyStimulus(4'b0001, 8'h00, 32'h000000A5);
        tick();
        checkOutput("load_c1_gnt", gnt, 4'b0001);
        checkOutput("load_c1_busy", busy, 1'b1);
        checkOutput("load_c1_en", ff_en, 1'b0);
        checkOutput("load_c1_ffd", ff_D, 8'hA5);
        tick();
        checkOutput("load_c2_en", ff_en, 1'b1);
        checkOutput("load_c2_ffd", ff_D, 8'hA5);
        checkOutput("load_c2_gnt", gnt, 4'b0001);
        checkOutput("load_c2_ack", ack, 4'b0000);
        tick();
        checkOutput("load_c3_ack", ack, 4'b0001);
        checkOutput("load_c3_en", ff_en, 1'b0);
        checkOutput("load_c3_gnt", gnt, 4'b0001);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("load_idle_busy", busy, 1'b0);
        checkOutput("load_idle_gnt", gnt, 4'b0000);
        checkOutput("load_idle_ack", ack, 4'b0000);
        checkOutput("load_rdata", rdata, 8'hA5);

        $display("[TB] op/din change after capture");
        applyStimulus(4'b0001, 8'h00, 32'h000000A5);
        tick();
        applyStimulus(4'b0001, 8'h01, 32'h00000000);
        tick();
        checkOutput("mid_en", ff_en, 1'b1);
        checkOutput("mid_clear", ff_clear, 1'b0);
        checkOutput("mid_ffd", ff_D, 8'hA5);
        tick();
        checkOutput("mid_ack", ack, 4'b0001);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("mid_rdata", rdata, 8'hA5);

        $display("[TB] clear then preset by requester 2");
        applyStimulus(4'b0100, 8'h10, 32'h00770000);
        tick();
        checkOutput("clr_gnt", gnt, 4'b0100);
        tick();
        checkOutput("clr_strobes", {ff_en, ff_clear, ff_preset}, 3'b010);
        tick();
        checkOutput("clr_ack", ack, 4'b0100);
        checkOutput("clr_c3_strobes", {ff_en, ff_clear, ff_preset}, 3'b000);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("clr_rdata", rdata, 8'h00);
        applyStimulus(4'b0100, 8'h20, 32'h00770000);
        tick();
        checkOutput("pre_gnt", gnt, 4'b0100);
        tick();
        checkOutput("pre_strobes", {ff_en, ff_clear, ff_preset}, 3'b001);
        tick();
        checkOutput("pre_ack", ack, 4'b0100);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("pre_rdata", rdata, 8'hFF);

        $display("[TB] reserved op by requester 3");
        applyStimulus(4'b1000, 8'hC0, 32'h12000000);
        tick();
        checkOutput("rsv_c1_busy", busy, 1'b1);
        checkOutput("rsv_c1_gnt", gnt, 4'b1000);
        tick();
        checkOutput("rsv_c2_busy", busy, 1'b1);
        checkOutput("rsv_c2_strobes", {ff_en, ff_clear, ff_preset}, 3'b000);
        tick();
        checkOutput("rsv_c3_busy", busy, 1'b1);
        checkOutput("rsv_c3_ack", ack, 4'b1000);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("rsv_idle_busy", busy, 1'b0);
        checkOutput("rsv_rdata", rdata, 8'hFF);

        $display("[TB] four-way contention");
        applyStimulus(4'b1111, 8'h00, 32'h13121110);
        for (int n = 0; n < 5; n++) begin
            exp_win = n % 4;
            tick();
            checkOutput("rr_gnt", gnt, 4'b0001 << exp_win);
            tick();
            checkOutput("rr_ffd", ff_D, 8'h10 + exp_win);
            checkOutput("rr_en", ff_en, 1'b1);
            tick();
            checkOutput("rr_ack", ack, 4'b0001 << exp_win);
            tick();
            checkOutput("rr_rdata", rdata, 8'h10 + exp_win);
        end
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();

        $display("[TB] reset during APPLY");
        applyStimulus(4'b0010, 8'h00, 32'h00005A00);
        tick();
        tick();
        checkOutput("ar_pre_en", ff_en, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_en", ff_en, 1'b0);
        checkOutput("ar_gnt", gnt, 4'b0000);
        checkOutput("ar_busy", busy, 1'b0);
        checkOutput("ar_ffd", ff_D, 8'h00);
        checkOutput("ar_rdata", rdata, 8'h00);
        applyStimulus(4'b0110, 8'h00, 32'h003C3C00);
        tick();
        checkOutput("ar_ack", ack, 4'b0000);
        checkOutput("ar_reg_kept", Q_in, 8'h10);
        reset_n = 1'b1;
        tick();
        checkOutput("ar_first_gnt", gnt, 4'b0010);
        tick();
        checkOutput("ar_first_ffd", ff_D, 8'h3C);
        tick();
        checkOutput("ar_first_ack", ack, 4'b0010);
        applyStimulus(4'b0000, 8'h00, 32'h0);
        tick();
        checkOutput("ar_first_rdata", rdata, 8'h3C);
        checkOutput("ar_end_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
